// File: rtl/traffic_phase_scheduler.sv
// Purpose: round-robin right-of-way scheduler for 4 vehicle phases + 1 ped phase (optional TLS_PREEMPT_EN).
// Latency: request seen in IDLE drives green/walk on the outputs after the next clock edge.
// Backpressure: none; requests are latched as pending until served, never dropped.
module traffic_phase_scheduler #(
    parameter int CNT_W            = 16,
    parameter int MIN_GREEN        = 10,
    parameter int MAX_GREEN        = 40,
    parameter int YELLOW_DURATION  = 5,
    parameter int ALL_RED_DURATION = 2,
    parameter int WALK_DURATION    = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] veh_req,
    input  logic       ped_req,
`ifdef TLS_PREEMPT_EN
    input  logic       preempt,
    input  logic [1:0] preempt_phase,
`endif
    output logic [7:0] lights,
    output logic       ped_walk,
    output logic [2:0] cur_phase
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GREEN,
        ST_YELLOW,
        ST_ALL_RED,
        ST_WALK
    } state_t;

    localparam logic [CNT_W-1:0] MIN_LAST  = CNT_W'(MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] MAX_LAST  = CNT_W'(MAX_GREEN - 1);
    localparam logic [CNT_W-1:0] YEL_LAST  = CNT_W'(YELLOW_DURATION - 1);
    localparam logic [CNT_W-1:0] AR_LAST   = CNT_W'(ALL_RED_DURATION - 1);
    localparam logic [CNT_W-1:0] WALK_LAST = CNT_W'(WALK_DURATION - 1);
    localparam logic [CNT_W-1:0] TIMER_MAX = '1;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic [1:0]       phase_q, phase_d;
    logic [3:0]       pend_q, pend_d;
    logic             pend_ped_q, pend_ped_d;
    logic [2:0]       last_q, last_d;
    logic [7:0]       lights_q, lights_d;
    logic             ped_walk_q, ped_walk_d;
    logic [2:0]       cur_phase_q, cur_phase_d;

    logic [4:0] view;
    logic       arb_vld;
    logic [2:0] arb_win;
    logic       compete;
    logic       arbitrate;
    logic       enter_green;
    logic [3:0] green_mask;
    logic [3:0] grant_mask;

    // Latched demand plus same-cycle requests; other-phase demand decides whether green may end.
    assign view    = {pend_ped_q | ped_req, pend_q | veh_req};
    assign compete = (|(view[3:0] & ~(4'b0001 << phase_q))) | view[4];

    // Round-robin search starting just after the last-served requester.
    always_comb begin
        int idx;
        arb_vld = 1'b0;
        arb_win = 3'd0;
        idx     = 0;
        for (int k = 1; k <= 5; k++) begin
            idx = (int'(last_q) + k) % 5;
            if (!arb_vld && view[idx]) begin
                arb_vld = 1'b1;
                arb_win = 3'(idx);
            end
        end
    end

    // Next-state, pending latches, timer and registered-output values.
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        last_d      = last_q;
        arbitrate   = 1'b0;
        lights_d    = 8'hFF;
        ped_walk_d  = 1'b0;
        cur_phase_d = 3'd7;

        case (state_q)
            ST_IDLE: arbitrate = 1'b1;
            ST_GREEN: begin
`ifdef TLS_PREEMPT_EN
                if (preempt) begin
                    if (preempt_phase != phase_q)
                        state_d = ST_YELLOW;
                end else
`endif
                if (timer_q >= MIN_LAST && compete &&
                    (!veh_req[phase_q] || timer_q >= MAX_LAST))
                    state_d = ST_YELLOW;
            end
            ST_YELLOW: if (timer_q == YEL_LAST) state_d = ST_ALL_RED;
            ST_WALK: begin
                if (timer_q == WALK_LAST) state_d = ST_ALL_RED;
`ifdef TLS_PREEMPT_EN
                if (preempt) state_d = ST_ALL_RED;
`endif
            end
            ST_ALL_RED: if (timer_q == AR_LAST) arbitrate = 1'b1;
            default: state_d = ST_IDLE;
        endcase

        if (arbitrate) begin
            state_d = ST_IDLE;
`ifdef TLS_PREEMPT_EN
            if (preempt) begin
                // Preemption bypasses the round-robin pointer entirely.
                state_d = ST_GREEN;
                phase_d = preempt_phase;
            end else
`endif
            if (arb_vld) begin
                last_d = arb_win;
                if (arb_win == 3'd4) begin
                    state_d = ST_WALK;
                end else begin
                    state_d = ST_GREEN;
                    phase_d = arb_win[1:0];
                end
            end
        end

        enter_green = (state_d == ST_GREEN) && (state_q != ST_GREEN);
        green_mask  = (state_q == ST_GREEN) ? (4'b0001 << phase_q) : 4'b0000;
        grant_mask  = enter_green ? (4'b0001 << phase_d) : 4'b0000;
        pend_d      = (pend_q | (veh_req & ~green_mask)) & ~grant_mask;
        pend_ped_d  = (pend_ped_q | ped_req) &
                      !((state_d == ST_WALK) && (state_q != ST_WALK));

        if (state_d != state_q)
            timer_d = '0;
        else if (timer_q == TIMER_MAX)
            timer_d = timer_q;
        else
            timer_d = timer_q + 1'b1;

        case (state_d)
            ST_GREEN: begin
                lights_d[{phase_d, 1'b0} +: 2] = 2'b10;
                cur_phase_d                    = {1'b0, phase_d};
            end
            ST_YELLOW: begin
                lights_d[{phase_d, 1'b0} +: 2] = 2'b01;
                cur_phase_d                    = {1'b0, phase_d};
            end
            ST_WALK: begin
                ped_walk_d  = 1'b1;
                cur_phase_d = 3'd4;
            end
            default: ;
        endcase
    end

    // State and output registers; reset forces all-red immediately.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            timer_q     <= '0;
            phase_q     <= 2'd0;
            pend_q      <= 4'd0;
            pend_ped_q  <= 1'b0;
            last_q      <= 3'd4;
            lights_q    <= 8'hFF;
            ped_walk_q  <= 1'b0;
            cur_phase_q <= 3'd7;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            phase_q     <= phase_d;
            pend_q      <= pend_d;
            pend_ped_q  <= pend_ped_d;
            last_q      <= last_d;
            lights_q    <= lights_d;
            ped_walk_q  <= ped_walk_d;
            cur_phase_q <= cur_phase_d;
        end
    end

    assign lights    = lights_q;
    assign ped_walk  = ped_walk_q;
    assign cur_phase = cur_phase_q;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Purpose: self-checking bench for traffic_phase_scheduler against a segment-level reference model.
// Latency: outputs compared every cycle on the falling edge after the model has seen the same inputs.
// Backpressure: not applicable.
module tb_traffic_phase_scheduler;

    localparam int MIN_G = 4;
    localparam int MAX_G = 10;
    localparam int YEL   = 2;
    localparam int AR    = 1;
    localparam int WALKD = 3;

    logic       clk;
    logic       reset;
    logic [3:0] veh_req;
    logic       ped_req;
    logic [7:0] lights;
    logic       ped_walk;
    logic [2:0] cur_phase;
`ifdef TLS_PREEMPT_EN
    logic       preempt;
    logic [1:0] preempt_phase;
    assign preempt       = 1'b0;
    assign preempt_phase = 2'd0;
`endif

    traffic_phase_scheduler #(
        .CNT_W(16), .MIN_GREEN(MIN_G), .MAX_GREEN(MAX_G),
        .YELLOW_DURATION(YEL), .ALL_RED_DURATION(AR), .WALK_DURATION(WALKD)
    ) dut (
        .clk(clk), .reset(reset), .veh_req(veh_req), .ped_req(ped_req),
`ifdef TLS_PREEMPT_EN
        .preempt(preempt), .preempt_phase(preempt_phase),
`endif
        .lights(lights), .ped_walk(ped_walk), .cur_phase(cur_phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: which segment the intersection is in, who holds it, how long.
    byte m_seg;
    int  m_who;
    int  m_age;
    int  m_last;
    bit  m_pend[5];
    bit  model_valid = 1'b0;
    logic [7:0] exp_lights;
    logic       exp_walk;
    logic [2:0] exp_cur;

    int cnt_g[4];
    int cnt_y[4];
    int cnt_w;
    bit rec_on = 1'b0;
    int order_q[$];
    int prev_cur;
    logic [3:0] vr;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step(input logic [3:0] v, input logic p, input logic r);
        bit view[5];
        bit other;
        bit arb;
        bit found;
        byte nseg;
        int nwho;
        int c;
        if (r) begin
            m_seg  = "I";
            m_who  = 7;
            m_age  = 0;
            m_last = 4;
            for (int q = 0; q < 5; q++) m_pend[q] = 1'b0;
            model_valid = 1'b1;
        end else begin
            for (int q = 0; q < 4; q++) view[q] = m_pend[q] | v[q];
            view[4] = m_pend[4] | p;
            nseg = m_seg;
            nwho = m_who;
            arb  = 1'b0;
            case (m_seg)
                "I": arb = 1'b1;
                "G": begin
                    other = 1'b0;
                    for (int q = 0; q < 5; q++)
                        if (q != m_who && view[q]) other = 1'b1;
                    if (m_age >= MIN_G - 1 && other && (!v[m_who] || m_age >= MAX_G - 1))
                        nseg = "Y";
                end
                "Y": if (m_age == YEL - 1) nseg = "R";
                "W": if (m_age == WALKD - 1) nseg = "R";
                "R": if (m_age == AR - 1) arb = 1'b1;
                default: nseg = "I";
            endcase
            if (arb) begin
                nseg  = "I";
                found = 1'b0;
                for (int k = 1; k <= 5; k++) begin
                    c = (m_last + k) % 5;
                    if (!found && view[c]) begin
                        found  = 1'b1;
                        nseg   = (c == 4) ? "W" : "G";
                        nwho   = c;
                        m_last = c;
                    end
                end
            end
            for (int q = 0; q < 4; q++)
                if (v[q] && !(m_seg == "G" && m_who == q)) m_pend[q] = 1'b1;
            if (p) m_pend[4] = 1'b1;
            if (nseg != m_seg) begin
                if (nseg == "G") m_pend[nwho] = 1'b0;
                if (nseg == "W") m_pend[4] = 1'b0;
                m_age = 0;
            end else if (m_age < 65535) begin
                m_age++;
            end
            m_seg = nseg;
            m_who = nwho;
        end
        exp_lights = 8'hFF;
        exp_walk   = (m_seg == "W");
        exp_cur    = 3'd7;
        if (m_seg == "G" || m_seg == "Y") begin
            exp_lights[2*m_who +: 2] = (m_seg == "G") ? 2'b10 : 2'b01;
            exp_cur = 3'(m_who);
        end
        if (m_seg == "W") exp_cur = 3'd4;
    endtask

    // One clock: check what the last edge produced, then apply new inputs.
    task automatic run_cycle(input logic [3:0] v, input logic p, input logic r);
        @(negedge clk);
        if (model_valid) begin
            check_val("lights", int'(lights), int'(exp_lights));
            check_val("ped_walk", int'(ped_walk), int'(exp_walk));
            check_val("cur_phase", int'(cur_phase), int'(exp_cur));
        end
        for (int q = 0; q < 4; q++) begin
            if (lights[2*q +: 2] == 2'b10) cnt_g[q]++;
            if (lights[2*q +: 2] == 2'b01) cnt_y[q]++;
        end
        if (ped_walk) cnt_w++;
        if (rec_on && int'(cur_phase) != prev_cur && cur_phase != 3'd7)
            order_q.push_back(int'(cur_phase));
        prev_cur = int'(cur_phase);
        veh_req = v;
        ped_req = p;
        reset   = r;
        model_step(v, p, r);
    endtask

    task automatic clear_counts();
        for (int q = 0; q < 4; q++) begin
            cnt_g[q] = 0;
            cnt_y[q] = 0;
        end
        cnt_w = 0;
    endtask

    task automatic do_reset();
        for (int i = 0; i < 3; i++) run_cycle(4'd0, 1'b0, 1'b1);
    endtask

    initial begin
        reset    = 1'b1;
        veh_req  = 4'd0;
        ped_req  = 1'b0;
        prev_cur = 7;

        // Reset state and quiet idle.
        do_reset();
        run_cycle(4'd0, 1'b0, 1'b0);
        check_val("rst_lights", int'(lights), 32'hFF);
        check_val("rst_walk", int'(ped_walk), 0);
        check_val("rst_cur", int'(cur_phase), 7);
        for (int i = 0; i < 20; i++) run_cycle(4'd0, 1'b0, 1'b0);
        check_val("idle_lights", int'(lights), 32'hFF);

        // Single pulse on phase 1, then rest in green.
        run_cycle(4'b0010, 1'b0, 1'b0);
        run_cycle(4'd0, 1'b0, 1'b0);
        check_val("p1_green", int'(lights[3:2]), 2);
        check_val("p1_cur", int'(cur_phase), 1);
        for (int i = 0; i < 50; i++) run_cycle(4'd0, 1'b0, 1'b0);
        check_val("p1_rest", int'(lights[3:2]), 2);

        // Max-out: phase 0 held, phase 2 pulse.
        do_reset();
        run_cycle(4'b0001, 1'b0, 1'b0);
        clear_counts();
        run_cycle(4'b0101, 1'b0, 1'b0);
        for (int i = 0; i < 19; i++) run_cycle(4'b0001, 1'b0, 1'b0);
        check_val("maxout_g0", cnt_g[0], MAX_G);
        check_val("maxout_y0", cnt_y[0], YEL);
        check_val("maxout_g2", cnt_g[2], MIN_G);

        // Gap-out into walk, then back to idle.
        do_reset();
        run_cycle(4'b0001, 1'b0, 1'b0);
        clear_counts();
        run_cycle(4'd0, 1'b1, 1'b0);
        for (int i = 0; i < 14; i++) run_cycle(4'd0, 1'b0, 1'b0);
        check_val("gap_g0", cnt_g[0], MIN_G);
        check_val("gap_y0", cnt_y[0], YEL);
        check_val("walk_len", cnt_w, WALKD);
        check_val("walk_idle", int'(cur_phase), 7);

        // Everyone requests at once: round-robin service order.
        do_reset();
        order_q.delete();
        rec_on = 1'b1;
        run_cycle(4'hF, 1'b1, 1'b0);
        for (int i = 0; i < 40; i++) run_cycle(4'd0, 1'b0, 1'b0);
        rec_on = 1'b0;
        check_val("order_len", order_q.size(), 5);
        for (int i = 0; i < order_q.size() && i < 5; i++)
            check_val("order", order_q[i], i);

        // Randomized traffic against the model.
        do_reset();
        vr = 4'd0;
        for (int i = 0; i < 3000; i++) begin
            for (int b = 0; b < 4; b++)
                if ($urandom_range(7) == 0) vr[b] = ~vr[b];
            run_cycle(vr, ($urandom_range(29) == 0), ($urandom_range(599) == 0));
        end
        run_cycle(4'd0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/traffic_phase_scheduler.md
# traffic_phase_scheduler

Demand-driven phase scheduler for a signalized intersection. Four vehicle phases and one pedestrian phase compete for right-of-way, and the block grants them in round-robin order. Each phase is sequenced through green, yellow and all-red clearance, with minimum-green, gap-out and max-out timing. It sits above the per-approach light drivers and owns the only copy of intersection state. The lights encoding is red 2'b11, yellow 2'b01, green 2'b10.

## Interface
- `CNT_W`, 16: timer width.
- `MIN_GREEN`, 10: minimum green cycles (≥1).
- `MAX_GREEN`, 40: green cap when competing demand exists (≥ MIN_GREEN).
- `YELLOW_DURATION`, 5: yellow cycles (≥1).
- `ALL_RED_DURATION`, 2: clearance cycles (≥1).
- `WALK_DURATION`, 20: pedestrian walk cycles (≥1).

Ports:
- `clk`  in  1  clock; one clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `veh_req`  in  4  per-phase vehicle detector, level; bit p = phase p.
- `ped_req`  in  1  pedestrian button, level or pulse.
- `lights`  out  8  registered; bits [2p+1:2p] = phase p light code.
- `ped_walk`  out  1  registered; 1 = walk.
- `cur_phase`  out  3  registered; 0-3 = vehicle phase in green/yellow, 4 = walk, 7 = none.
- `preempt`, `preempt_phase[1:0]`  in: present only with `TLS_PREEMPT_EN`.

## Operation
- States: IDLE, GREEN, YELLOW, ALL_RED, WALK. A timer counts cycles in the current state and clears on every transition.
- Pending latches:
  - `pend[p]` sets on `veh_req[p]` and clears on entry to GREEN for phase p.
  - `pend_ped` sets on `ped_req` and clears on entry to WALK.
  - A request for the phase currently green is not latched. A request during its own yellow is latched.
- Arbitration:
  - Requesters 0,1,2,3,ped(4) are searched round-robin, starting after the last-served requester.
  - The arbitration view is `pend | incoming req`, so a same-cycle request is seen.
  - Arbitration is evaluated in IDLE every cycle and on the final ALL_RED cycle.
  - Winner 0-3 → GREEN for that phase. Winner 4 → WALK. No demand → IDLE.
- GREEN:
  - Timer < MIN_GREEN-1: stay.
  - After MIN_GREEN cycles, with competing demand (any other `pend`, or `pend_ped`): go to YELLOW on gap-out (own `veh_req` low) or on max-out (MAX_GREEN cycles elapsed).
  - With no competing demand: rest in green indefinitely.
- YELLOW: exactly YELLOW_DURATION cycles, then ALL_RED.
- WALK: exactly WALK_DURATION cycles with `ped_walk`=1 and all vehicle phases red, then ALL_RED.
- ALL_RED: exactly ALL_RED_DURATION cycles, then arbitrate as above.
- Outputs:
  - Only the active phase is non-red.
  - `cur_phase`=7 in IDLE and ALL_RED.

## Timing
- Reset, which wins over all other events, leaves: state IDLE, `lights`=8'hFF, `ped_walk`=0, `cur_phase`=7, all pend cleared, last-served=4 (so phase 0 has first priority).
- Reset asserted mid-phase forces all-red on the next edge, with no yellow.
- Request in IDLE at cycle t → green (or walk) visible after edge t+1.
- Phase handoff cost: YELLOW_DURATION + ALL_RED_DURATION cycles. There is no idle cycle when demand is pending.
- Timer saturates at 2^CNT_W-1 during rest-in-green and does not wrap.
- Simultaneous competing request and gap-out in the same cycle: the transition to YELLOW occurs that cycle.

## Configuration
- `TLS_PREEMPT_EN` defined:
  - `preempt` high in GREEN of another phase → YELLOW immediately, ignoring MIN_GREEN.
  - `preempt` high in WALK → ALL_RED immediately.
  - The next arbitration grants `preempt_phase` unconditionally, then holds it green while `preempt` stays high.
  - When `preempt` drops, normal min/gap/max rules resume from the current timer.
  - Round-robin pointer is unchanged by preemption.
- Undefined: `preempt` ports absent; no preemption logic.

## Test plan
Parameters: MIN_GREEN=4, MAX_GREEN=10, YELLOW_DURATION=2, ALL_RED_DURATION=1, WALK_DURATION=3.
1. Reset held 3 cycles → `lights`=8'hFF, `ped_walk`=0, `cur_phase`=7; no change for 20 cycles with no requests.
2. `veh_req`=4'b0010 pulsed 1 cycle in IDLE → `lights`[3:2]=10 one edge later, `cur_phase`=1; stays green ≥50 cycles with no other demand.
3. Phase 0 green, `veh_req[0]` held high, `veh_req[2]` pulse → green exactly 10 cycles, yellow 2, all-red 1, then phase 2 green.
4. Phase 0 green, `veh_req[0]` low, `ped_req` pulse at green cycle 0 → yellow after 4 green cycles; walk 3 cycles with `cur_phase`=4; then all-red 1, then IDLE.
5. From reset, `veh_req`=4'hF and `ped_req` pulsed together → service order 0,1,2,3,walk, each separated by the correct yellow/all-red counts.
6. (`TLS_PREEMPT_EN`) Phase 1 green at cycle 1, `preempt`=1 with `preempt_phase`=3 → yellow next edge, all-red, phase 3 green held while `preempt`=1.
